// File: rtl/vecgen_pkg.sv
// rtl/vecgen_pkg.sv - shared widths and state encoding for the vector generator sequencer
package vecgen_pkg;
    localparam int DV_W         = 12;
    localparam int VEL_SIGN_BIT = 10;
    localparam int VEL_MAG_W    = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        SETTLE
    } seq_state_t;
endpackage

// File: rtl/vec_down_timer.sv
// rtl/vec_down_timer.sv - loadable down-counter with registered zero flag, stops at zero
module vec_down_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         zero
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_value;
            zero  <= (load_value == '0);
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
            zero  <= (count == W'(1));
        end
    end
endmodule

// File: rtl/vec_segment_seq.sv
// rtl/vec_segment_seq.sv - segment sequencer driving load/run/settle strobes of one axis position counter
module vec_segment_seq
    import vecgen_pkg::*;
#(
    parameter int LEN_W         = 12,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DV_W-1:0]   cmd_pos,
    input  logic [DV_W-1:0]   cmd_vel,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_beam,
    input  logic              halt_req,
    output logic [DV_W-1:0]   dv,
    output logic              go,
    output logic              haltstrobe,
    output logic              timer0,
    output logic              beam_on,
    output logic              busy,
    output logic              seg_done,
    output logic              seg_abort
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    seq_state_t       state, state_d;
    logic [DV_W-1:0]  dv_d, vel_q, vel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [SET_W-1:0] settle_cnt, settle_d;
    logic             go_d, hs_d, t0_d, beam_d, done_d, abort_d;
    logic             beam_q, beamq_d, abort_q, abortq_d;
    logic             timer_load, timer_en, timer_zero;
    logic [LEN_W-1:0] timer_count;

    assign cmd_ready = (state == IDLE) && !halt_req && !reset;

    vec_down_timer #(.W(LEN_W)) u_run_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .enable     (timer_en),
        .load_value (len_q),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    always_comb begin
        state_d    = state;
        dv_d       = dv;
        go_d       = go;
        hs_d       = haltstrobe;
        t0_d       = timer0;
        beam_d     = beam_on;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        vel_d      = vel_q;
        len_d      = len_q;
        beamq_d    = beam_q;
        abortq_d   = abort_q;
        settle_d   = settle_cnt;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    vel_d    = cmd_vel;
                    len_d    = cmd_len;
                    beamq_d  = cmd_beam;
                    abortq_d = 1'b0;
                    dv_d     = cmd_pos;
                    hs_d     = 1'b1;
                    t0_d     = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                hs_d = 1'b0;
                if (halt_req || (len_q == '0)) begin
                    abortq_d = halt_req;
                    go_d     = 1'b0;
                    t0_d     = 1'b1;
                    settle_d = SET_W'(SETTLE_CYCLES);
                    state_d  = SETTLE;
                end else begin
                    dv_d       = vel_q;
                    go_d       = 1'b1;
                    beam_d     = beam_q;
                    timer_load = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                timer_en = 1'b1;
                // halt wins over a coinciding last run cycle
                if (halt_req || (timer_count == LEN_W'(1)) || timer_zero) begin
                    abortq_d = halt_req;
                    go_d     = 1'b0;
                    beam_d   = 1'b0;
                    t0_d     = 1'b1;
                    settle_d = SET_W'(SETTLE_CYCLES);
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt <= SET_W'(1)) begin
                    state_d = IDLE;
                    done_d  = !abort_q;
                    abort_d = abort_q;
                end else begin
                    settle_d = settle_cnt - SET_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dv         <= '0;
            go         <= 1'b0;
            haltstrobe <= 1'b0;
            timer0     <= 1'b1;
            beam_on    <= 1'b0;
            busy       <= 1'b0;
            seg_done   <= 1'b0;
            seg_abort  <= 1'b0;
            vel_q      <= '0;
            len_q      <= '0;
            beam_q     <= 1'b0;
            abort_q    <= 1'b0;
            settle_cnt <= '0;
        end else begin
            state      <= state_d;
            dv         <= dv_d;
            go         <= go_d;
            haltstrobe <= hs_d;
            timer0     <= t0_d;
            beam_on    <= beam_d;
            busy       <= (state_d != IDLE);
            seg_done   <= done_d;
            seg_abort  <= abort_d;
            vel_q      <= vel_d;
            len_q      <= len_d;
            beam_q     <= beamq_d;
            abort_q    <= abortq_d;
            settle_cnt <= settle_d;
        end
    end
endmodule
